fwd_scoreboard: RTL

Parametrised forwarding and hazard unit for the pipelined core. It tracks every in-flight register write in a tag shift register, one entry per stage between decode and write-back. For each decode-stage source operand it produces a bypass-select code, and it raises a load-use stall when the youngest producer's data is not ready yet. It generalises fixed EX/MEM/WB forwarding to any operand count, pipeline depth and load latency, and adds flush handling and a stall-cycle counter.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_scoreboard_if.sv | 33 +++
 rtl/fwd_match.sv | 41 ++++
 rtl/fwd_scoreboard.sv | 92 +++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard scoreboard.
package fwd_pkg;

    // Entries store rd at a fixed width so the struct needs no parameters.
    localparam int FWD_RD_W   = 8;
    localparam int FWD_CNT_W  = 16;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                is_load;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle: operand/destination info in, bypass selects and stall out.
interface fwd_scoreboard_if
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 3,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
);
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_rd_addr;
    logic                          id_rd_we;
    logic                          id_is_load;
    logic                          flush;
    logic [FWD_DEPTH-1:0]          flush_mask;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;
    logic [FWD_CNT_W-1:0]          stall_cnt;

    modport master (
        output id_valid, id_src_addr, id_src_used, id_rd_addr, id_rd_we, id_is_load,
        output flush, flush_mask,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_rd_addr, id_rd_we, id_is_load,
        input  flush, flush_mask,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_match.sv
// Priority search of the in-flight tags for one source operand; youngest match wins.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int FWD_DEPTH  = 3,
    parameter int MEM_LAT    = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  fwd_entry_t [FWD_DEPTH-1:0] entries_i,
    input  logic [REG_ADDR_W-1:0]      src_addr_i,
    input  logic                       src_used_i,
    output logic [SEL_W-1:0]           sel_o,
    output logic                       unready_o
);

    logic hit;
    int   win_k;
    logic win_load;
    logic ready;

    // Scan oldest to youngest so the lowest matching index is the last one written.
    always_comb begin
        hit      = 1'b0;
        win_k    = 0;
        win_load = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (src_used_i && entries_i[k].valid &&
                (entries_i[k].rd == FWD_RD_W'(src_addr_i))) begin
                hit      = 1'b1;
                win_k    = k;
                win_load = entries_i[k].is_load;
            end
        end
    end

    assign ready     = !(win_load && (win_k < MEM_LAT));
    assign sel_o     = (hit && ready) ? SEL_W'(win_k + 1) : SEL_W'(FWD_SEL_RF);
    assign unready_o = hit && !ready;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: tag shift register from EX to WB, per-operand bypass select, load-use stall.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 3,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 3,
    parameter int MEM_LAT    = 1,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input logic              clk,
    input logic              rst_n,
    fwd_scoreboard_if.slave  bus
);

    logic [FWD_DEPTH-1:0] vld_q, vld_d;
    logic [FWD_DEPTH-1:0] ld_q, ld_d;
    logic [FWD_RD_W-1:0]  rd_q [FWD_DEPTH];
    logic [FWD_RD_W-1:0]  rd_d [FWD_DEPTH];
    logic [FWD_CNT_W-1:0] cnt_q, cnt_d;

    fwd_entry_t [FWD_DEPTH-1:0] entries;
    logic [NUM_SRC-1:0]         unready;
    logic                       stall;
    logic                       issue;

    function automatic logic [FWD_CNT_W-1:0] sat_inc(input logic [FWD_CNT_W-1:0] v,
                                                     input logic              en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        for (int k = 0; k < FWD_DEPTH; k++) begin
            entries[k] = '{valid: vld_q[k], rd: rd_q[k], is_load: ld_q[k]};
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(
            .REG_ADDR_W(REG_ADDR_W),
            .FWD_DEPTH (FWD_DEPTH),
            .MEM_LAT   (MEM_LAT),
            .SEL_W     (SEL_W)
        ) u_match (
            .entries_i (entries),
            .src_addr_i(bus.id_src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
            .src_used_i(bus.id_src_used[s]),
            .sel_o     (bus.fwd_sel[s*SEL_W +: SEL_W]),
            .unready_o (unready[s])
        );
    end

    // A younger unready producer stalls even when an older ready copy exists.
    assign stall = bus.id_valid && !bus.flush && (|unready);
    assign issue = bus.id_valid && bus.id_rd_we && !stall && !bus.flush;

    always_comb begin
        vld_d = '0;
        ld_d  = '0;
        rd_d  = '{default: '0};
        vld_d[0] = issue;
        rd_d[0]  = FWD_RD_W'(bus.id_rd_addr);
        ld_d[0]  = bus.id_is_load;
        // The kill mask is indexed by the entry before it shifts.
        for (int k = 1; k < FWD_DEPTH; k++) begin
            vld_d[k] = vld_q[k-1] && !bus.flush_mask[k-1];
            rd_d[k]  = rd_q[k-1];
            ld_d[k]  = ld_q[k-1];
        end
        cnt_d = sat_inc(cnt_q, stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
        ld_q <= ld_d;
    end

    assign bus.stall     = stall;
    assign bus.stall_cnt = cnt_q;

endmodule
